// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, runs the I-cache request/ready handshake
// and drives the IF/ID register, with a one-entry hold buffer for stalled returns.
module if_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN     = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        br_taken,
    input  logic [31:0] br_addr,
    output logic        ic_req,
    output logic [31:0] ic_addr,
    input  logic        ic_rdy,
    input  logic [31:0] ic_rd_data,
    output logic        if_busy,
    output logic [31:0] if_pc,
    output logic [31:0] if_insn,
    output logic        if_en
);

    typedef enum logic [1:0] {REQ, MISS, HOLD} state_t;

    state_t      state, state_d;
    logic [31:0] pc, pc_d;
    logic [31:0] hold_insn, hold_d;
    logic        rd_pend, rd_pend_d;
    logic [31:0] rd_addr, rd_addr_d;
    logic [31:0] if_pc_d, if_insn_d;
    logic        if_en_d;

    logic        redir;
    logic [31:0] tgt;

    assign redir = flush | br_taken;
    assign tgt   = {(flush ? new_pc[31:2] : br_addr[31:2]), 2'b00};

    // Handshake outputs depend only on state/pc so control can feed if_busy
    // back into stall without forming a loop.
    assign ic_req  = (state != HOLD);
    assign ic_addr = pc;
    assign if_busy = ic_req & ~ic_rdy;

    always_comb begin
        state_d   = state;
        pc_d      = pc;
        hold_d    = hold_insn;
        rd_pend_d = rd_pend;
        rd_addr_d = rd_addr;
        if_pc_d   = if_pc;
        if_insn_d = if_insn;
        if_en_d   = if_en;
        case (state)
            REQ: begin
                if (redir) begin
                    pc_d      = tgt;
                    if_en_d   = 1'b0;
                    if_insn_d = NOP_INSN;
                end else if (ic_rdy) begin
                    if (!stall) begin
                        if_pc_d   = pc;
                        if_insn_d = ic_rd_data;
                        if_en_d   = 1'b1;
                        pc_d      = pc + 32'd4;
                    end
                end else begin
                    state_d = MISS;
                end
            end
            MISS: begin
                if (ic_rdy) begin
                    if (redir || rd_pend) begin
                        // The newest redirect wins over one captured earlier in the miss.
                        pc_d      = redir ? tgt : rd_addr;
                        rd_pend_d = 1'b0;
                        if_en_d   = 1'b0;
                        if_insn_d = NOP_INSN;
                        state_d   = REQ;
                    end else if (!stall) begin
                        if_pc_d   = pc;
                        if_insn_d = ic_rd_data;
                        if_en_d   = 1'b1;
                        pc_d      = pc + 32'd4;
                        state_d   = REQ;
                    end else begin
                        hold_d  = ic_rd_data;
                        state_d = HOLD;
                    end
                end else if (redir) begin
                    rd_pend_d = 1'b1;
                    rd_addr_d = tgt;
                    if_en_d   = 1'b0;
                    if_insn_d = NOP_INSN;
                end
            end
            HOLD: begin
                if (redir) begin
                    pc_d      = tgt;
                    if_en_d   = 1'b0;
                    if_insn_d = NOP_INSN;
                    state_d   = REQ;
                end else if (!stall) begin
                    if_pc_d   = pc;
                    if_insn_d = hold_insn;
                    if_en_d   = 1'b1;
                    pc_d      = pc + 32'd4;
                    state_d   = REQ;
                end
            end
            default: state_d = REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= REQ;
            pc        <= RESET_VECTOR;
            hold_insn <= NOP_INSN;
            rd_pend   <= 1'b0;
            rd_addr   <= RESET_VECTOR;
            if_pc     <= 32'd0;
            if_insn   <= NOP_INSN;
            if_en     <= 1'b0;
        end else begin
            state     <= state_d;
            pc        <= pc_d;
            hold_insn <= hold_d;
            rd_pend   <= rd_pend_d;
            rd_addr   <= rd_addr_d;
            if_pc     <= if_pc_d;
            if_insn   <= if_insn_d;
            if_en     <= if_en_d;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed cycles, a per-cycle fetch-unit model and literal spot checks.
module tb_if_fetch;

    localparam logic [31:0] RV  = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, flush = 1'b0, br_taken = 1'b0, ic_rdy = 1'b0;
    logic [31:0] new_pc = '0, br_addr = '0, ic_rd_data = '0;
    logic        ic_req, if_busy, if_en;
    logic [31:0] ic_addr, if_pc, if_insn;

    if_fetch #(.RESET_VECTOR(RV), .NOP_INSN(NOP)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
        .br_taken(br_taken), .br_addr(br_addr), .ic_req(ic_req), .ic_addr(ic_addr),
        .ic_rdy(ic_rdy), .ic_rd_data(ic_rd_data), .if_busy(if_busy),
        .if_pc(if_pc), .if_insn(if_insn), .if_en(if_en)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the fetcher either is waiting on an outstanding word, owns a
    // fetched-but-undelivered word, or is free to issue; redirects seen while
    // waiting are remembered until the word comes back.
    logic [31:0] m_pc, m_word, m_redir_to, m_if_pc, m_if_insn;
    bit          m_waiting, m_owns_word, m_redir_saved, m_if_en;
    bit          r;
    logic [31:0] t;

    always @(posedge clk) begin
        r = flush | br_taken;
        t = (flush ? new_pc : br_addr) & 32'hFFFF_FFFC;
        if (rst) begin
            m_pc = RV; m_waiting = 0; m_owns_word = 0; m_redir_saved = 0;
            m_if_pc = 0; m_if_insn = NOP; m_if_en = 0;
        end else if (m_owns_word) begin
            if (r) begin
                m_owns_word = 0; m_pc = t; m_if_en = 0; m_if_insn = NOP;
            end else if (!stall) begin
                m_owns_word = 0; m_if_pc = m_pc; m_if_insn = m_word; m_if_en = 1;
                m_pc = m_pc + 4;
            end
        end else if (m_waiting) begin
            if (ic_rdy) begin
                m_waiting = 0;
                if (r || m_redir_saved) begin
                    m_pc = r ? t : m_redir_to; m_redir_saved = 0;
                    m_if_en = 0; m_if_insn = NOP;
                end else if (!stall) begin
                    m_if_pc = m_pc; m_if_insn = ic_rd_data; m_if_en = 1; m_pc = m_pc + 4;
                end else begin
                    m_owns_word = 1; m_word = ic_rd_data;
                end
            end else if (r) begin
                m_redir_saved = 1; m_redir_to = t; m_if_en = 0; m_if_insn = NOP;
            end
        end else begin
            if (r) begin
                m_pc = t; m_if_en = 0; m_if_insn = NOP;
            end else if (ic_rdy) begin
                if (!stall) begin
                    m_if_pc = m_pc; m_if_insn = ic_rd_data; m_if_en = 1; m_pc = m_pc + 4;
                end
            end else begin
                m_waiting = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("ic_req", {31'd0, ic_req}, {31'd0, !m_owns_word});
            chk("ic_addr", ic_addr, m_pc);
            chk("if_busy", {31'd0, if_busy}, {31'd0, !m_owns_word && !ic_rdy});
            chk("if_pc", if_pc, m_if_pc);
            chk("if_insn", if_insn, m_if_insn);
            chk("if_en", {31'd0, if_en}, {31'd0, m_if_en});
        end
    end

    // One cycle of stimulus; the cache returns a word tagged with its address.
    task automatic step(input bit s, input bit f, input logic [31:0] np, input bit b,
                        input logic [31:0] ba, input bit rdy, input bit rs = 1'b0);
        rst = rs; stall = s; flush = f; new_pc = np; br_taken = b; br_addr = ba;
        ic_rdy = rdy; ic_rd_data = {16'hA5A5, m_pc[15:0]};
        @(posedge clk);
        #1;
    endtask

    task automatic hit();  step(0, 0, 0, 0, 0, 1); endtask
    task automatic wait_c(); step(0, 0, 0, 0, 0, 0); endtask

    initial begin
        #1;
        step(0, 0, 0, 0, 0, 0, 1);
        chk_on = 1'b1;
        chk("rst ic_addr", ic_addr, 32'h0);
        chk("rst ic_req", {31'd0, ic_req}, 32'd1);
        chk("rst if_en", {31'd0, if_en}, 32'd0);
        chk("rst if_insn", if_insn, NOP);
        chk("rst if_pc", if_pc, 32'h0);

        hit(); chk("hit0 if_pc", if_pc, 32'h0); chk("hit0 if_en", {31'd0, if_en}, 32'd1);
        chk("hit0 ic_addr", ic_addr, 32'h4);
        hit(); chk("hit1 if_pc", if_pc, 32'h4);
        hit(); chk("hit2 if_pc", if_pc, 32'h8); chk("hit2 ic_addr", ic_addr, 32'hC);
        hit(); chk("hit3 if_pc", if_pc, 32'hC);

        wait_c(); wait_c(); wait_c();
        chk("miss ic_addr", ic_addr, 32'h10);
        chk("miss if_busy", {31'd0, if_busy}, 32'd1);
        hit();
        chk("miss if_pc", if_pc, 32'h10); chk("miss if_insn", if_insn, 32'hA5A5_0010);
        chk("miss next addr", ic_addr, 32'h14);

        wait_c();
        step(1, 0, 0, 0, 0, 1);
        chk("hold ic_req", {31'd0, ic_req}, 32'd0); chk("hold if_pc", if_pc, 32'h10);
        step(1, 0, 0, 0, 0, 0);
        chk("hold2 ic_req", {31'd0, ic_req}, 32'd0);
        wait_c();
        chk("hold out if_pc", if_pc, 32'h14); chk("hold out insn", if_insn, 32'hA5A5_0014);
        chk("hold out addr", ic_addr, 32'h18);
        wait_c();
        chk("no dup if_pc", if_pc, 32'h14);

        step(0, 0, 0, 1, 32'h103, 0);
        chk("br miss if_en", {31'd0, if_en}, 32'd0);
        hit();
        chk("br miss addr", ic_addr, 32'h100); chk("br miss insn", if_insn, NOP);
        hit(); chk("after br if_pc", if_pc, 32'h100);

        step(0, 1, 32'h200, 1, 32'h300, 1);
        chk("flush addr", ic_addr, 32'h200); chk("flush insn", if_insn, NOP);
        chk("flush if_en", {31'd0, if_en}, 32'd0);
        step(1, 0, 0, 0, 0, 1);
        chk("stall hit addr", ic_addr, 32'h200);

        step(0, 1, 32'hFFFF_FFFF, 0, 0, 0);
        chk("wrap pc", ic_addr, 32'hFFFF_FFFC);
        hit();
        chk("wrap if_pc", if_pc, 32'hFFFF_FFFC); chk("wrap addr", ic_addr, 32'h0);

        wait_c();
        step(0, 0, 0, 1, 32'h40, 0);
        step(0, 1, 32'h80, 0, 0, 0);
        hit(); chk("newest redir", ic_addr, 32'h80);
        wait_c();
        step(0, 1, 32'h90, 0, 0, 1); chk("redir at rdy", ic_addr, 32'h90);

        wait_c();
        step(1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 1, 32'h500, 0);
        chk("hold redir addr", ic_addr, 32'h500); chk("hold redir req", {31'd0, ic_req}, 32'd1);

        wait_c();
        step(0, 0, 0, 0, 0, 1, 1);
        chk("rst mid addr", ic_addr, RV); chk("rst mid if_en", {31'd0, if_en}, 32'd0);
        hit(); chk("post rst if_pc", if_pc, 32'h0);
        hit(); hit();

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
